rr_mux_arb: RTL
===============

// Module: rr_mux_arb
// PURPOSE
//  Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake.
//  Operates in one of two modes, chosen per cycle:
//   - fixed-select: Selector picks the source.
//   - round-robin: a fair rotating grant picks the source.
//  Replaces the combinational 4-to-1 operand mux where sources are decoupled producers (regfile, ALU, mem, imm).
//  One output register stage gives fully synchronous timing to the downstream stage.
// PARAMETERS
//  NUM_CH  4   number of input channels, >=2, need not be a power of two
//  WIDTH   32  data width per channel
//  SEL_W   $clog2(NUM_CH) (min 1)  width of Selector and out_ch
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  Mode       in   1              0 = fixed-select (MODE_FIXED), 1 = round-robin (MODE_RR)
//  Selector   in   SEL_W          channel index used in fixed-select mode
//  in_valid   in   NUM_CH         per-channel data valid
//  in_ready   out  NUM_CH         per-channel accept; one-hot or zero
//  in_data    in   NUM_CH*WIDTH   channel k occupies bits [k*WIDTH +: WIDTH]
//  out_valid  out  1              registered output valid
//  out_ready  in   1              downstream accept
//  out_data   out  WIDTH          registered selected data (Result)
//  out_ch     out  SEL_W          index of the channel that produced out_data
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
//   - in_ready is combinational; it is 0 while rst_n=0.
//  load = !out_valid || out_ready (single-register pipe; full throughput).
//  Grant, combinational:
//   - MODE_FIXED: g=Selector, granted iff in_valid[Selector].
//   - Selector >= NUM_CH: no grant.
//   - MODE_RR: g is the first k with in_valid[k], searching ptr, ptr+1, ... with wrap mod NUM_CH.
//  Handshake:
//   - in_ready[g] = load && granted; all other in_ready bits are 0.
//   - A transfer occurs when in_valid[g] && in_ready[g].
//  Latency: data accepted in cycle t appears on out_data/out_ch with out_valid=1 in cycle t+1.
//  Output register:
//   - If load && granted: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
//   - Else if out_ready: out_valid <= 0; out_data and out_ch hold.
//   - Else (out_valid && !out_ready): stall; all outputs hold stable.
//  RR pointer:
//   - Updates only on a transfer in MODE_RR: ptr <= (g==NUM_CH-1) ? 0 : g+1.
//   - Unchanged in MODE_FIXED.
//  Boundaries:
//   - No valid input: no transfer; out_valid drains when out_ready.
//   - Stall: in_ready all 0; Selector/Mode changes are ignored until load.
//   - Simultaneous drain and fill (out_valid && out_ready && granted): new data is loaded the same cycle, no bubble.
//   - Mode switch takes effect in the next grant evaluation; ptr is kept.
//   - Non-power-of-two NUM_CH: wrap at NUM_CH-1, never at 2^SEL_W-1.
//   - rst_n low mid-transfer: outputs clear immediately; the in-flight beat is dropped.
// STRUCTURE
//  Header mux_defs.vh holds MODE_FIXED=1'b0, MODE_RR=1'b1 and a clog2 function shared with the datapath.
//  Sub-module rr_grant (combinational; NUM_CH, SEL_W):
//   - inputs req[NUM_CH], ptr; outputs gnt_idx, gnt_any.
//   - double-width rotate + priority encode.
//  Top level holds the mode mux, the output register and the ptr register.
// TESTING
//  1 Reset: assert rst_n=0 with all valids high.
//    -> out_valid=0, out_data=0, in_ready=0, async with no clk edge.
//  2 Fixed mode: R0..R3 = DEADBEEF, CAFEBABE, 0BADF00D, 01234567, all valid, out_ready=1; Selector 0,1,2,3.
//    -> out_data follows one cycle later with out_ch = Selector.
//    -> Selector=2 with in_valid[2]=0: no transfer, out_valid falls.
//  3 Round-robin: all four valid, out_ready=1 for 8 cycles.
//    -> out_ch sequence 0,1,2,3,0,1,2,3; one beat per cycle.
//    -> Only ch1,ch3 valid: sequence 1,3,1,3.
//  4 Backpressure: hold out_ready=0 for 3 cycles after a beat of DEADBEEF.
//    -> out_data stays DEADBEEF, in_ready=0, no ptr advance.
//    -> Releasing out_ready loads the next beat in the same cycle.
//  5 Odd width/depth: NUM_CH=3, WIDTH=8, RR mode, all valid.
//    -> out_ch 0,1,2,0; Selector=3 in fixed mode never grants.
//  6 Reset mid-stream: pull rst_n low for 1 cycle during RR traffic.
//    -> out_valid=0 immediately; after release the first grant is ch0 (ptr=0).

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the round-robin / fixed-select output mux.
// Holds the mode encoding and the select-width helper used by every file.
package rr_mux_arb_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // Index width for n channels, never below one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between N producers, the mux and one consumer.
// master: producer/consumer side; slave: the mux itself.
interface rr_mux_arb_if
    import rr_mux_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = sel_width(NUM_CH)
);

    logic                    Mode;
    logic [SEL_W-1:0]        Selector;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;

    modport master (
        output Mode, Selector, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  Mode, Selector, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_mux_arb_grant.sv
// Combinational rotating-priority grant: first request at or after ptr.
// Ports: req (requests), ptr (start index) -> gnt_idx, gnt_any.
module rr_mux_arb_grant #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [SEL_W:0]      off;
    logic [SEL_W:0]      sum;

    always_comb begin
        // Rotating the doubled vector puts req[ptr] at bit 0.
        dbl = {req, req} >> ptr;
        rot = dbl[NUM_CH-1:0];
        off = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) off = (SEL_W+1)'(k);
        end
        // Map the offset back to a channel, wrapping at NUM_CH.
        sum = {1'b0, ptr} + off;
        if (sum >= (SEL_W+1)'(NUM_CH)) begin
            sum = sum - (SEL_W+1)'(NUM_CH);
        end
        gnt_idx = sum[SEL_W-1:0];
        gnt_any = |req;
    end

endmodule

// File: rtl/rr_mux_arb.sv
// Registered N-to-1 mux with fixed-select or round-robin grant.
// Ports: clk, rst_n (async low), bus (slave side of rr_mux_arb_if).
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_mux_arb_if.slave  bus
);

    localparam logic [SEL_W:0] NCH = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0] ch_data [NUM_CH];
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [SEL_W-1:0] gnt_idx;
    logic             granted;
    logic             load;
    logic [NUM_CH-1:0] in_ready_c;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch_data[k] = bus.in_data[k*WIDTH +: WIDTH];
    end

    rr_mux_arb_grant #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_grant (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    always_comb begin
        load = !out_valid_q || bus.out_ready;
        if (bus.Mode == MODE_RR) begin
            gnt_idx = rr_idx;
            granted = rr_any;
        end else begin
            gnt_idx = bus.Selector;
            // Out-of-range selectors never grant.
            granted = ({1'b0, bus.Selector} < NCH)
                      && bus.in_valid[bus.Selector];
        end
    end

    always_comb begin
        in_ready_c = '0;
        if (rst_n && load && granted) begin
            in_ready_c[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load && granted) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[gnt_idx];
            out_ch_d    = gnt_idx;
            if (bus.Mode == MODE_RR) begin
                ptr_d = (gnt_idx == LAST) ? '0 : gnt_idx + SEL_W'(1);
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule
